uart_frame_tx: RTL
==================

// Module: uart_frame_tx
// PURPOSE
//   Serial byte transmitter placed directly downstream of the character sender.
//   It takes one byte per send_en pulse and drives an 8N1 RS-232 frame on
//   rs232_tx at the rate selected by baud_set.
//   It reports frame completion with a one-cycle tx_done pulse, which the
//   character sender uses to issue the next byte of its 17-byte burst.
// PARAMETERS
//   CLK_HZ     50_000_000  pixelclk frequency in Hz; used to derive the bit period
//   STOP_BITS  1           stop bits per frame; legal values are 1 and 2
// PORTS
//   pixelclk    in   1  sole clock; all logic is on the rising edge
//   reset_n     in   1  synchronous reset, active-low; sampled on the pixelclk rising edge
//   send_en     in   1  one-cycle request; latch data_byte and start a frame
//   baud_set    in   3  rate select: 0=9600 1=19200 2=38400 3=57600 4=115200, 5..7=115200
//   data_byte   in   8  byte to send; sampled only in the send_en accept cycle
//   rs232_tx    out  1  serial line; idles high
//   tx_done     out  1  one-cycle pulse after the last stop bit completes
//   uart_state  out  1  1 while a frame is in progress (busy)
// BEHAVIOUR
//   - Reset: reset_n=0 at a clock edge forces rs232_tx=1, tx_done=0, uart_state=0.
//     It also clears the FSM to IDLE, the divider and bit counters, and the shift register.
//   - Reset mid-frame aborts the frame immediately. No tx_done is produced.
//   - Bit period: DIV = (CLK_HZ + baud/2) / baud, computed per baud_set at elaboration.
//     The divider counter is $clog2(CLK_HZ/9600+1) bits wide.
//     The counter runs 0..DIV-1, then wraps and advances the bit.
//   - FSM states and transitions:
//     - IDLE -> START when send_en=1. data_byte and baud_set are latched in that same cycle.
//     - START (rs232_tx=0, DIV cycles) -> DATA.
//     - DATA: 8 bits, LSB first, DIV cycles each. A 3-bit counter moves the FSM to STOP after bit 7.
//     - STOP (rs232_tx=1, STOP_BITS*DIV cycles) -> DONE.
//     - DONE lasts 1 cycle: tx_done=1, uart_state=0, rs232_tx=1, then -> IDLE.
//   - Accepting send_en:
//     - send_en is accepted in IDLE and in DONE.
//     - If send_en=1 in DONE, the FSM goes straight to START, so frames run back to back.
//     - send_en while in START/DATA/STOP is ignored. The frame in flight and its latched byte are not disturbed.
//   - Latency:
//     - send_en accepted at edge N -> rs232_tx=0 and uart_state=1 from N+1.
//     - tx_done=1 for exactly the cycle N+1+(9+STOP_BITS)*DIV.
//     - uart_state is 1 for exactly (9+STOP_BITS)*DIV cycles per frame.
//   - A change on baud_set or data_byte during a frame has no effect until the next accept.
//   - All outputs are registered. rs232_tx never glitches between bits.
// TESTING
//   Bench parameters: CLK_HZ=1_152_000, STOP_BITS=1, giving DIV=10 at baud_set=4 and DIV=120 at baud_set=0.
//   1. Reset: hold reset_n=0 for 5 cycles with send_en=1.
//      -> rs232_tx=1, tx_done=0, uart_state=0 throughout; no frame starts.
//   2. Single frame: send_en=1 with data_byte=8'h0A, baud_set=4 at cycle N.
//      -> line carries 0,0,1,0,1,0,0,0,0,1, each bit lasting 10 cycles.
//      -> tx_done=1 only at N+101; uart_state=1 over N+1..N+100.
//   3. Back-to-back burst: feed send_en from tx_done for 17 bytes (8'h0A then 8'h41..8'h50).
//      -> 17 frames, each separated by exactly 1 idle-high cycle.
//      -> decoded bytes match in order; 17 tx_done pulses.
//   4. Busy collision: mid-DATA (bit 3), pulse send_en with data_byte=8'hFF.
//      -> ignored; the original 8'h0A frame completes unchanged; only one tx_done.
//   5. Rate select: baud_set=0 -> bit period 120 cycles, tx_done at N+1201.
//      baud_set=7 -> identical timing to baud_set=4.
//      baud_set changed mid-frame -> no timing change.
//   6. Reset mid-frame: assert reset_n=0 during DATA bit 4.
//      -> rs232_tx=1 and uart_state=0 after that edge; no tx_done.
//      -> a subsequent send_en with 8'h55 produces a correct full frame.

Source files
------------

// File: rtl/uart_frame_tx.sv
// 8N1 serial byte transmitter with per-frame selectable baud rate.
// Emits a one-cycle tx_done pulse after the final stop bit so a sender can chain frames.
module uart_frame_tx #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       pixelclk,
    input  logic       reset_n,
    input  logic       send_en,
    input  logic [2:0] baud_set,
    input  logic [7:0] data_byte,
    output logic       rs232_tx,
    output logic       tx_done,
    output logic       uart_state
);

    localparam int unsigned CW = $clog2(CLK_HZ / 9600 + 1);

    localparam int unsigned DIV_9600   = (CLK_HZ + 4800) / 9600;
    localparam int unsigned DIV_19200  = (CLK_HZ + 9600) / 19200;
    localparam int unsigned DIV_38400  = (CLK_HZ + 19200) / 38400;
    localparam int unsigned DIV_57600  = (CLK_HZ + 28800) / 57600;
    localparam int unsigned DIV_115200 = (CLK_HZ + 57600) / 115200;

    localparam logic [CW-1:0] LIM_9600   = CW'(DIV_9600 - 1);
    localparam logic [CW-1:0] LIM_19200  = CW'(DIV_19200 - 1);
    localparam logic [CW-1:0] LIM_38400  = CW'(DIV_38400 - 1);
    localparam logic [CW-1:0] LIM_57600  = CW'(DIV_57600 - 1);
    localparam logic [CW-1:0] LIM_115200 = CW'(DIV_115200 - 1);

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] div_lim_q, div_lim_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] sel_lim;
    logic          wrap;

    always_comb begin
        sel_lim = LIM_115200;
        case (baud_set)
            3'd0:    sel_lim = LIM_9600;
            3'd1:    sel_lim = LIM_19200;
            3'd2:    sel_lim = LIM_38400;
            3'd3:    sel_lim = LIM_57600;
            default: sel_lim = LIM_115200;
        endcase
    end

    assign wrap = (div_cnt_q == div_lim_q);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_lim_d  = div_lim_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            IDLE, DONE: begin
                if (send_en) begin
                    state_d    = START;
                    shift_d    = data_byte;
                    div_lim_d  = sel_lim;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (wrap) begin
                    div_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (wrap) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d    = STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (wrap) begin
                    div_cnt_d = '0;
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = DONE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without a cycle of lag.
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            STOP: busy_d = 1'b1;
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            div_lim_q  <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_lim_q  <= div_lim_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rs232_tx   = tx_q;
    assign tx_done    = done_q;
    assign uart_state = busy_q;

endmodule
